// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with zero-skew registered sync/enable outputs.
// Define VGA_SYNC_FRAME_CNT_EN to add the 8-bit frame_count output.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       VGA_clk,
    input  logic       rst,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic [7:0] frame_count,
`endif
    output logic [9:0] x_count,
    output logic [9:0] y_count,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic       x_wrap;
    logic       at_origin;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    always_comb begin
        x_wrap    = x_count == H_LAST;
        x_nxt     = x_wrap ? '0 : x_count + 10'd1;
        y_nxt     = !x_wrap ? y_count : (y_count == V_LAST ? '0 : y_count + 10'd1);
        at_origin = x_nxt == '0 && y_nxt == '0;
    end

    // Outputs are decoded from the next counter values so they line up with the counters.
    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            x_count     <= H_LAST;
            y_count     <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x_count     <= x_nxt;
            y_count     <= y_nxt;
            hsync       <= !(x_nxt >= HS_ON && x_nxt < HS_OFF);
            vsync       <= !(y_nxt >= VS_ON && y_nxt < VS_OFF);
            display_on  <= x_nxt < H_VIS && y_nxt < V_VIS;
            frame_start <= at_origin;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Reset to all-ones so the first frame after release reads zero.
    always_ff @(posedge VGA_clk) begin
        if (rst)
            frame_count <= 8'hFF;
        else if (at_origin)
            frame_count <= frame_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized-reset bench comparing a small-timing and a default-timing
// instance every cycle against an arithmetic raster model (position from elapsed cycles).
module tb_vga_sync_gen;
    logic VGA_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 VGA_clk = ~VGA_clk;

    logic [9:0] sx, sy, bx, by;
    logic       shs, svs, sde, sfs, bhs, bvs, bde, bfs;
    logic [7:0] sfc, bfc;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = -1;

`ifndef VGA_SYNC_FRAME_CNT_EN
    assign sfc = 8'h00;
    assign bfc = 8'h00;
`endif

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .VGA_clk(VGA_clk),
        .rst(rst),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_count(sfc),
`endif
        .x_count(sx),
        .y_count(sy),
        .hsync(shs),
        .vsync(svs),
        .display_on(sde),
        .frame_start(sfs)
    );

    vga_sync_gen u_big (
        .VGA_clk(VGA_clk),
        .rst(rst),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_count(bfc),
`endif
        .x_count(bx),
        .y_count(by),
        .hsync(bhs),
        .vsync(bvs),
        .display_on(bde),
        .frame_start(bfs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    // Reference: t cycles after release the beam is at (t mod htot, t div htot mod vtot).
    task automatic model_cmp(input string n, input int ha, hf, hs, hb, va, vf, vs, vb,
                             input logic [9:0] x, y, input logic h, v, d, f,
                             input logic [7:0] fc);
        int htot, vtot, ex, ey;
        logic eh, ev, ed, ef;
        logic [7:0] efc;
        htot = ha + hf + hs + hb;
        vtot = va + vf + vs + vb;
        if (t < 0) begin
            ex = htot - 1; ey = vtot - 1;
            eh = 1'b1; ev = 1'b1; ed = 1'b0; ef = 1'b0; efc = 8'hFF;
        end else begin
            ex  = t % htot;
            ey  = (t / htot) % vtot;
            eh  = !(ex >= ha + hf && ex < ha + hf + hs);
            ev  = !(ey >= va + vf && ey < va + vf + vs);
            ed  = ex < ha && ey < va;
            ef  = (t % (htot * vtot)) == 0;
            efc = 8'((t / (htot * vtot)) % 256);
        end
        check({n, ".x"}, 32'(x), 32'(ex));
        check({n, ".y"}, 32'(y), 32'(ey));
        check({n, ".hsync"}, 32'(h), 32'(eh));
        check({n, ".vsync"}, 32'(v), 32'(ev));
        check({n, ".display_on"}, 32'(d), 32'(ed));
        check({n, ".frame_start"}, 32'(f), 32'(ef));
`ifdef VGA_SYNC_FRAME_CNT_EN
        check({n, ".frame_count"}, 32'(fc), 32'(efc));
`endif
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge VGA_clk);
        t = r ? -1 : t + 1;
        @(negedge VGA_clk);
        model_cmp("small", 8, 1, 2, 1, 4, 1, 2, 1, sx, sy, shs, svs, sde, sfs, sfc);
        model_cmp("big", 640, 16, 96, 48, 480, 10, 2, 33, bx, by, bhs, bvs, bde, bfs, bfc);
    endtask

    initial begin
        int hold;
        int guard;
        hold = 0;
        repeat (3) step(1'b1);
        // Randomly timed resets of random length land anywhere in the raster.
        for (int i = 0; i < 5000; i++) begin
            if (hold == 0 && $urandom_range(0, 299) == 0) hold = $urandom_range(1, 4);
            if (hold > 0) begin
                hold--;
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        // Reset while the small instance is inside both sync pulses.
        guard = 0;
        while (!(sx == 10'd9 && sy == 10'd5) && guard < 200) begin
            step(1'b0);
            guard++;
        end
        check("reach_sync_window", 32'(guard < 200), 32'd1);
        step(1'b1);
        step(1'b1);
        // Long uninterrupted run: many small frames and frame_count rollover.
        for (int i = 0; i < 96 * 258 + 10; i++) step(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that sits directly downstream of the VGA pixel-clock divider.
- Clocked by the divided pixel clock VGA_clk.
- Produces the horizontal and vertical counters, the active-low sync pulses, the display-enable flag and the frame-start strobe.
- Its outputs are consumed by the snake/board renderer and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024.

Ports:
- VGA_clk  input  1  pixel clock from the divider; all logic is on its rising edge
- rst  input  1  synchronous, active-high reset
- x_count  output  10  current pixel column, 0..H_TOTAL-1
- y_count  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- display_on  output  1  high while (x_count, y_count) lies in the visible area
- frame_start  output  1  one-cycle pulse while x_count=0 and y_count=0
- frame_count  output  8  frame counter; present only with the optional feature

Behaviour:
- Reset is synchronous and active-high: it is sampled only on a VGA_clk rising edge.
- Reset state, forced every edge while rst=1:
  - x_count=H_TOTAL-1 (799), y_count=V_TOTAL-1 (524)
  - hsync=1, vsync=1, display_on=0, frame_start=0
- First edge with rst=0: counters wrap to (0,0), display_on=1, frame_start=1.
- Horizontal counter:
  - increments by 1 every cycle
  - at H_TOTAL-1 it wraps to 0 on the next edge
- Vertical counter:
  - increments only on the edge where x_count wraps
  - at V_TOTAL-1 with x_count=H_TOTAL-1, both counters wrap to 0 together
- All outputs are registered and self-consistent: in any cycle, hsync/vsync/display_on/frame_start describe the x_count/y_count present in that same cycle (zero skew, computed from next-state counter values).
- hsync=0 iff H_ACTIVE+H_FP ≤ x_count < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync=0 iff V_ACTIVE+V_FP ≤ y_count < V_ACTIVE+V_FP+V_SYNC (490..491). vsync is line-aligned: it changes only when x_count=0.
- display_on=1 iff x_count < H_ACTIVE and y_count < V_ACTIVE.
- frame_start=1 for exactly one cycle per frame, period H_TOTAL*V_TOTAL = 420000 cycles.
- Reset asserted mid-frame: the next edge enters the reset state immediately and no partial sync pulse is stretched. After release, timing restarts from (0,0) exactly as after power-up.
- No enable input: the counters free-run whenever rst=0.

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined:
  - 8-bit frame_count output exists; reset value 8'hFF.
  - Increments on every edge where frame_start becomes 1, so the first frame after reset reads 0.
  - Wraps 255→0.
  - Used by the game logic as the snake movement tick source.
- Undefined: the frame_count port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset/release: hold rst=1 for 3 cycles → x=799, y=524, hsync=1, vsync=1, display_on=0. Release → next cycle x=0, y=0, display_on=1, frame_start=1.
- Horizontal timing: run one line → hsync low for exactly 96 cycles at x=656..751; display_on high for x=0..639 on line 0 and low for x=640..799; x wraps 799→0 while y goes 0→1.
- Vertical timing: run a full frame → vsync low exactly for y=490..491 (1600 cycles), first asserted at x=0,y=490; display_on never high for y≥480.
- Frame period: measure between frame_start pulses → exactly 420000 cycles; each pulse is 1 cycle wide; y wraps 524→0 together with x wrap.
- Mid-frame reset: assert rst at x=700, y=491 (during both syncs) → next edge hsync=1, vsync=1, counters at (799,524). Release → new frame starts at (0,0) with a single frame_start.
- With VGA_SYNC_FRAME_CNT_EN: frame_count=0 in the first frame after reset, increments once per frame_start, and reads 0 again after 256 frames (rollover).
